bpsk_tx_sched: RTL

- Frame scheduler in front of the BPSK IQ mapper.
- On a start request it feeds the mapper's 128-bit chunk input in order: PRE_CHUNKS fixed preamble chunks, then len payload chunks popped from a first-word-fall-through (FWFT) payload FIFO.
- Uses the mapper's reader_en pulse as the chunk-accept acknowledge.
- Waits for the mapper to drain, holds an inter-frame gap, then pulses done.

---
 rtl/bpsk_tx_pkg.sv | 19 +
 rtl/bpsk_tx_stage.sv | 32 +++
 rtl/bpsk_tx_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bpsk_tx_pkg.sv
// Shared definitions for the BPSK transmit frame scheduler: chunk width,
// default preamble word and the one-hot state encoding.
package bpsk_tx_pkg;

   localparam int CHUNK_W = 128;

   // Alternating 1010... pattern, i.e. 128'hAAAA...AAAA.
   localparam logic [CHUNK_W-1:0] PRE_WORD_DEFAULT = {(CHUNK_W/2){2'b10}};

   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_PRE   = 6'b000010,
      S_PAY   = 6'b000100,
      S_POST  = 6'b001000,
      S_DRAIN = 6'b010000,
      S_GAP   = 6'b100000
   } state_t;

endpackage

// File: rtl/bpsk_tx_stage.sv
// Chunk staging register between the scheduler and the BPSK mapper:
// holds one 128-bit chunk plus its valid bit, with load/ack/flush control.
module bpsk_tx_stage
   import bpsk_tx_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               load,
   input  logic [CHUNK_W-1:0] din,
   input  logic               ack,
   input  logic               flush,
   output logic               valid,
   output logic [CHUNK_W-1:0] data
);

   // An acknowledge or flush always wins; a new chunk only enters an empty stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (ce) begin
         if (flush || ack) begin
            valid <= 1'b0;
         end else if (load && !valid) begin
            data  <= din;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/bpsk_tx_sched.sv
// Frame scheduler in front of the BPSK IQ mapper: preamble chunks, payload
// chunks from an FWFT FIFO, drain, inter-frame gap, done pulse.
// Optional postamble chunk enabled by defining BPSK_TX_SCHED_POSTAMBLE_EN.
module bpsk_tx_sched
   import bpsk_tx_pkg::*;
#(
   parameter int                 PRE_CHUNKS = 2,
   parameter logic [CHUNK_W-1:0] PRE_WORD   = PRE_WORD_DEFAULT,
   parameter int                 GAP_CYCLES = 16
`ifdef BPSK_TX_SCHED_POSTAMBLE_EN
   ,
   parameter logic [CHUNK_W-1:0] POST_WORD  = ~PRE_WORD
`endif
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ce,
   input  logic               start,
   input  logic [7:0]         len,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               underrun,
   input  logic               fifo_empty,
   input  logic [8:0]         fifo_count,
   input  logic [CHUNK_W-1:0] fifo_dout,
   output logic               fifo_rd,
   output logic               map_valid,
   output logic [CHUNK_W-1:0] map_data,
   input  logic               map_ack,
   input  logic               map_busy
);

   localparam logic [3:0] PRE_N    = 4'(PRE_CHUNKS);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t             state;
   logic [3:0]         pre_cnt;
   logic [7:0]         len_q;
   logic [7:0]         issued;
   logic [7:0]         acked;
   logic [7:0]         gap_cnt;

   logic               chunk_ack;
   logic               abort_now;
   logic               start_ok;
   logic               stage_load;
   logic               stage_flush;
   logic               pay_load;
   logic               starve;
   logic [CHUNK_W-1:0] stage_din;

   assign chunk_ack   = map_ack & map_valid;
   assign abort_now   = abort & (state != S_IDLE);
   assign start_ok    = start & (len != 8'd0) & ({1'b0, len} <= fifo_count);
   assign stage_flush = abort_now | (state == S_DRAIN);

   // Decide what, if anything, goes into the empty staging register this cycle.
   always_comb begin
      stage_load = 1'b0;
      stage_din  = PRE_WORD;
      pay_load   = 1'b0;
      starve     = 1'b0;
      case (state)
         S_PRE: begin
            stage_load = !map_valid && (pre_cnt < PRE_N);
         end
         S_PAY: begin
            if (!map_valid && (issued < len_q)) begin
               if (fifo_empty) begin
                  starve = 1'b1;
               end else begin
                  pay_load   = 1'b1;
                  stage_load = 1'b1;
                  stage_din  = fifo_dout;
               end
            end
         end
`ifdef BPSK_TX_SCHED_POSTAMBLE_EN
         S_POST: begin
            stage_load = !map_valid;
            stage_din  = POST_WORD;
         end
`endif
         default: begin
            stage_load = 1'b0;
         end
      endcase
      if (abort_now) begin
         stage_load = 1'b0;
         pay_load   = 1'b0;
         starve     = 1'b0;
      end
   end

   assign fifo_rd = ce & ~RST & pay_load;
   assign done    = ce & ~RST & ~abort & (state == S_GAP) & (gap_cnt == GAP_LAST);
   assign busy    = (state != S_IDLE);

   bpsk_tx_stage u_stage (
      .clk   (CLK),
      .rst   (RST),
      .ce    (ce),
      .load  (stage_load),
      .din   (stage_din),
      .ack   (chunk_ack),
      .flush (stage_flush),
      .valid (map_valid),
      .data  (map_data)
   );

   // Frame sequencing; abort from any active state restarts the drain/gap tail.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         pre_cnt  <= '0;
         len_q    <= '0;
         issued   <= '0;
         acked    <= '0;
         gap_cnt  <= '0;
         underrun <= 1'b0;
      end else if (ce) begin
         if (abort_now) begin
            state   <= S_DRAIN;
            gap_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_ok) begin
                     len_q    <= len;
                     pre_cnt  <= '0;
                     issued   <= '0;
                     acked    <= '0;
                     gap_cnt  <= '0;
                     underrun <= 1'b0;
                     state    <= S_PRE;
                  end
               end
               S_PRE: begin
                  if (chunk_ack) begin
                     pre_cnt <= pre_cnt + 4'd1;
                     if (pre_cnt + 4'd1 == PRE_N) begin
                        state <= S_PAY;
                     end
                  end
               end
               S_PAY: begin
                  if (pay_load) begin
                     issued <= issued + 8'd1;
                  end
                  if (starve) begin
                     underrun <= 1'b1;
                     state    <= S_DRAIN;
                  end else if (chunk_ack) begin
                     acked <= acked + 8'd1;
                     if (acked + 8'd1 == len_q) begin
`ifdef BPSK_TX_SCHED_POSTAMBLE_EN
                        state <= S_POST;
`else
                        state <= S_DRAIN;
`endif
                     end
                  end
               end
`ifdef BPSK_TX_SCHED_POSTAMBLE_EN
               S_POST: begin
                  if (chunk_ack) begin
                     state <= S_DRAIN;
                  end
               end
`endif
               S_DRAIN: begin
                  if (!map_busy) begin
                     gap_cnt <= '0;
                     state   <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     state <= S_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + 8'd1;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
